// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, decode read ports and the write-back stage.
// The master side drives the pipeline inputs; the slave side is the register file itself.
interface wb_regfile_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  logic [WIDTH-1:0]     ReadDataW;
  logic [WIDTH-1:0]     ALUOutW;
  logic [3:0]           WA3W;
  logic                 MemToRegW;
  logic                 RegWriteW;
  logic                 PCSrcW;
  logic [3:0]           RA1D;
  logic [3:0]           RA2D;
  logic [WIDTH-1:0]     PCPlus8D;
  logic [WIDTH-1:0]     RD1D;
  logic [WIDTH-1:0]     RD2D;
  logic [WIDTH-1:0]     ResultW;
  logic                 PCRedirect;
  logic [WIDTH-1:0]     PCTarget;
  logic [CNT_WIDTH-1:0] RetireCount;

  modport master (
    output ReadDataW, ALUOutW, WA3W, MemToRegW, RegWriteW, PCSrcW,
    output RA1D, RA2D, PCPlus8D,
    input  RD1D, RD2D, ResultW, PCRedirect, PCTarget, RetireCount
  );

  modport slave (
    input  ReadDataW, ALUOutW, WA3W, MemToRegW, RegWriteW, PCSrcW,
    input  RA1D, RA2D, PCPlus8D,
    output RD1D, RD2D, ResultW, PCRedirect, PCTarget, RetireCount
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and R0-R14 register file with PC-redirect pulse and retire counter.
// Define WB_BYPASS_EN to make the read ports write-through for a register being written this cycle.
module wb_regfile #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  localparam logic [3:0] PC_IDX = 4'd15;

  logic [WIDTH-1:0]     r_regs [0:14];
  logic                 r_redirect;
  logic [WIDTH-1:0]     r_target;
  logic [CNT_WIDTH-1:0] r_retire;

  logic [WIDTH-1:0]     w_result;
  logic                 w_wrEn;
  logic                 w_bypassEn;
  logic [WIDTH-1:0]     w_rd1;
  logic [WIDTH-1:0]     w_rd2;

  assign w_result = bus.MemToRegW ? bus.ReadDataW : bus.ALUOutW;
  // R15 is the PC: it is never stored here, only redirected through PCSrcW.
  assign w_wrEn   = bus.RegWriteW && (bus.WA3W != PC_IDX);

`ifdef WB_BYPASS_EN
  // Forwarding is suppressed while reset is held so the read ports show the cleared file.
  assign w_bypassEn = w_wrEn && reset;
`else
  assign w_bypassEn = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (w_wrEn && (bus.WA3W == 4'(i))) begin
          r_regs[i] <= w_result;
        end
      end
    end
  end

  always_comb begin
    w_rd1 = bus.PCPlus8D;
    if (bus.RA1D != PC_IDX) begin
      w_rd1 = r_regs[bus.RA1D];
      if (w_bypassEn && (bus.RA1D == bus.WA3W)) begin
        w_rd1 = w_result;
      end
    end
  end

  always_comb begin
    w_rd2 = bus.PCPlus8D;
    if (bus.RA2D != PC_IDX) begin
      w_rd2 = r_regs[bus.RA2D];
      if (w_bypassEn && (bus.RA2D == bus.WA3W)) begin
        w_rd2 = w_result;
      end
    end
  end

  // An instruction that both writes a register and the PC retires once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_redirect <= 1'b0;
      r_target   <= '0;
      r_retire   <= '0;
    end else begin
      r_redirect <= bus.PCSrcW;
      if (bus.PCSrcW) begin
        r_target <= w_result;
      end
      if (bus.RegWriteW || bus.PCSrcW) begin
        r_retire <= r_retire + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.ResultW     = w_result;
  assign bus.RD1D        = w_rd1;
  assign bus.RD2D        = w_rd2;
  assign bus.PCRedirect  = r_redirect;
  assign bus.PCTarget    = r_target;
  assign bus.RetireCount = r_retire;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a reference model pushes expected values to a queue
// as stimulus is driven, and each DUT observation pops and asserts against it.
module tb_wb_regfile;
  localparam int WIDTH = 32;
  localparam int CW    = 4;

  logic clk;
  logic reset;

  wb_regfile_if #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) bus ();

  wb_regfile #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] expQ [$];
  int          assertCount = 0;
  int          failCount   = 0;

  logic [31:0] mRegs [15];
  logic        mRedir;
  logic [31:0] mTarget;
  logic [CW-1:0] mCount;

  function automatic logic [31:0] modelResult();
    return bus.MemToRegW ? bus.ReadDataW : bus.ALUOutW;
  endfunction

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    if (a == 4'd15) return bus.PCPlus8D;
`ifdef WB_BYPASS_EN
    if (reset && bus.RegWriteW && bus.WA3W != 4'd15 && a == bus.WA3W) return modelResult();
`endif
    return mRegs[a];
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 15; i++) mRegs[i] = '0;
    mRedir  = 1'b0;
    mTarget = '0;
    mCount  = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed);
    logic [31:0] expected;
    assertCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h, scoreboard empty", tag, observed);
    end else begin
      expected = expQ.pop_front();
      assert (observed === expected) else begin
        failCount++;
        $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic ms, input logic ps,
                               input logic [3:0] wa, input logic [31:0] rdata,
                               input logic [31:0] alu);
    bus.RegWriteW = rw;
    bus.MemToRegW = ms;
    bus.PCSrcW    = ps;
    bus.WA3W      = wa;
    bus.ReadDataW = rdata;
    bus.ALUOutW   = alu;
  endtask

  task automatic readCheck(input logic [3:0] a1, input logic [3:0] a2);
    bus.RA1D = a1;
    bus.RA2D = a2;
    #1;
    expQ.push_back(modelRead(a1));
    expQ.push_back(modelRead(a2));
    checkOutput($sformatf("rd1[%0d]", a1), bus.RD1D);
    checkOutput($sformatf("rd2[%0d]", a2), bus.RD2D);
  endtask

  task automatic checkRegState(input string tag);
    expQ.push_back({31'b0, mRedir});
    expQ.push_back(mTarget);
    expQ.push_back({{(32-CW){1'b0}}, mCount});
    checkOutput({tag, "_redirect"}, {31'b0, bus.PCRedirect});
    checkOutput({tag, "_target"}, bus.PCTarget);
    checkOutput({tag, "_retire"}, {{(32-CW){1'b0}}, bus.RetireCount});
  endtask

  // One clock with the currently driven inputs; model commits what the edge should.
  task automatic cycle(input string tag);
    logic [31:0] res;
    #1;
    res = modelResult();
    expQ.push_back(res);
    checkOutput({tag, "_result"}, bus.ResultW);
    if (bus.RegWriteW && bus.WA3W != 4'd15) mRegs[bus.WA3W] = res;
    mRedir = bus.PCSrcW;
    if (bus.PCSrcW) mTarget = res;
    if (bus.RegWriteW || bus.PCSrcW) mCount = mCount + 1'b1;
    @(posedge clk);
    #1;
    checkRegState(tag);
  endtask

  initial begin
    reset = 1'b0;
    bus.PCPlus8D = 32'h0000_1008;
    bus.RA1D = '0;
    bus.RA2D = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, '0, '0);
    resetModel();

    // Reset state: every address, both ports.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) readCheck(4'(i), 4'(15 - i));
    checkRegState("reset");
    reset = 1'b1;

    // Load result into R3, then ALU result into R4.
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF, 32'h0000_1234);
    cycle("wr_r3");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, '0, '0);
    readCheck(4'd3, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd4, 32'hDEAD_BEEF, 32'h0000_1234);
    cycle("wr_r4");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, '0, '0);
    readCheck(4'd4, 4'd3);

    // Same-cycle read of the register being written.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 32'h0, 32'hA5A5_A5A5);
    readCheck(4'd4, 4'd5);
    cycle("wr_r5");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, '0, '0);
    readCheck(4'd5, 4'd5);

    // PC write for two cycles, then idle.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd15, 32'h0, 32'h0000_0200);
    readCheck(4'd15, 4'd3);
    cycle("pc_w1");
    cycle("pc_w2");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, '0, '0);
    cycle("pc_idle");
    for (int i = 0; i < 15; i++) readCheck(4'(i), 4'(i));

    // Reset mid-operation while a redirect pulse is live.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, 32'h0, 32'h0000_1111);
    cycle("wr_r7");
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, 32'h0, 32'h0000_0077);
    bus.RA1D = 4'd7;
    #2;
    reset = 1'b0;
    resetModel();
    readCheck(4'd7, 4'd3);
    checkRegState("async_rst");
    @(posedge clk);
    #1;
    checkRegState("rst_edge");
    #2;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, '0, '0);
    readCheck(4'd7, 4'd3);
    cycle("post_rst");
    readCheck(4'd7, 4'd4);

    // Counter wrap: 17 retiring cycles interleaved with 5 bubbles from zero.
    for (int i = 0; i < 22; i++) begin
      if (i % 4 == 2 && i < 20) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 4'(i), $urandom, $urandom);
      end else if (i % 4 == 3) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd15, $urandom, $urandom);
      end else begin
        applyStimulus(1'b1, 1'(i % 2), 1'b0, 4'(i % 15), $urandom, $urandom);
      end
      cycle($sformatf("wrap%0d", i));
    end
    expQ.push_back(32'd1);
    checkOutput("wrap_final", {{(32-CW){1'b0}}, bus.RetireCount});
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, '0, '0);
    for (int i = 0; i < 15; i++) readCheck(4'(i), 4'(14 - i));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the pipelined ARM core. It sits at the far end of the MEM/WB pipeline register. It selects the write-back result, commits it to R0–R14 and serves the two decode-stage read ports. It also turns a PC-writing instruction into a registered branch-redirect pulse for fetch, and keeps a retired-instruction counter for debug and performance readout.

## Interface
Parameters:
- WIDTH, 32, datapath and register width.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ReadDataW  in  WIDTH  load data from MEM/WB.
- ALUOutW  in  WIDTH  ALU result from MEM/WB.
- WA3W  in  4  destination register index.
- MemToRegW  in  1  1 selects ReadDataW as result, 0 selects ALUOutW.
- RegWriteW  in  1  register write enable.
- PCSrcW  in  1  instruction writes PC.
- RA1D, RA2D  in  4  decode read addresses.
- PCPlus8D  in  WIDTH  value returned when a read address is 15.
- RD1D, RD2D  out  WIDTH  decode read data.
- ResultW  out  WIDTH  combinational write-back result.
- PCRedirect  out  1  registered one-cycle redirect pulse.
- PCTarget  out  WIDTH  registered redirect target.
- RetireCount  out  CNT_WIDTH  retired-instruction count.

## Operation
- ResultW = MemToRegW ? ReadDataW : ALUOutW. This is purely combinational.
- Register file:
  - 15 entries, R0–R14.
  - On a rising edge with RegWriteW=1 and WA3W≠15, regs[WA3W] ← ResultW.
  - A write with WA3W=15 is never stored; PC writes go through PCSrcW only.
- Reads (combinational):
  - RAxD=15 returns PCPlus8D.
  - Otherwise returns regs[RAxD], subject to bypass (see Configuration).
  - Both ports may name the same register; both return the same value.
- Redirect:
  - On a rising edge with PCSrcW=1: PCRedirect ← 1 and PCTarget ← ResultW.
  - Otherwise PCRedirect ← 0 and PCTarget holds its value.
  - PCSrcW high on N consecutive edges gives N consecutive pulses, each with that cycle's target.
- Retire counter:
  - Increments by 1 on each rising edge where RegWriteW | PCSrcW.
  - An instruction with both signals set counts once.
  - Bubbles (both low) do not count.
  - Wraps from 2^CNT_WIDTH−1 to 0 with no flag.
- Reset (reset=0):
  - Immediately and asynchronously clears regs, PCRedirect, PCTarget and RetireCount to 0.
  - A write or redirect presented on the edge coinciding with reset is discarded.
  - After reset deasserts, the first rising edge operates normally.

## Timing
- Write latency: the value is visible in stored state after the rising edge on which RegWriteW is sampled.
- Read ports: zero latency, combinational from RAxD, PCPlus8D and the register state.
- PCRedirect/PCTarget: valid exactly one cycle after the PCSrcW sample edge, high for exactly one cycle per sampled PCSrcW.
- RetireCount: reflects all edges up to and including the most recent one.
- Reset values: RD1D/RD2D = PCPlus8D when the address is 15, else 0. PCRedirect=0, PCTarget=0, RetireCount=0. ResultW follows its inputs.

## Configuration
- WB_BYPASS_EN defined:
  - When RegWriteW=1, WA3W≠15 and RAxD=WA3W, RDxD returns ResultW in the same cycle (write-through).
  - This applies independently to each port.
- WB_BYPASS_EN undefined:
  - Reads always return stored regs.
  - A same-cycle read of a register being written returns the old value; the hazard unit must stall or forward.

## Test plan
- Reset, then read all addresses with PCPlus8D=0x0000_1008 → RD=0 for addresses 0–14, RD=0x0000_1008 for address 15. PCRedirect=0, RetireCount=0.
- Write back, both result sources:
  - RegWriteW=1, WA3W=3, MemToRegW=1, ReadDataW=0xDEAD_BEEF, ALUOutW=0x1234 → next cycle RA1D=3 reads 0xDEAD_BEEF.
  - Repeat with MemToRegW=0 on R4 → R4 reads 0x1234.
- Same-cycle read of the register being written: write R5=0xA5A5_A5A5 while RA2D=5.
  - With WB_BYPASS_EN: RD2D=0xA5A5_A5A5 in that cycle.
  - Without it: RD2D=old value, new value on the next cycle.
- PC write: PCSrcW=1, RegWriteW=1, WA3W=15, ALUOutW=0x0000_0200 for 2 consecutive cycles, then 0 → PCRedirect high for exactly 2 cycles with PCTarget=0x200. R0–R14 unchanged. RetireCount +2.
- Counter wrap: CNT_WIDTH=4, 17 retiring cycles interleaved with 5 bubbles → RetireCount=1 (wrapped once), bubbles not counted.
- Reset mid-operation: assert reset low mid-cycle while RegWriteW=1, WA3W=7, PCSrcW=1 → R7=0, PCRedirect=0 and RetireCount=0 immediately; the write is not committed after release.
